// File: rtl/mem_req_arbiter_if.sv
// Bundle of requester handshakes and the main-memory port shared by the arbiter.
// The arbiter side uses the master modport; the requester/memory side uses slave.
interface mem_req_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ack;
  logic              req0_err;
  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ack;
  logic              req1_err;
  logic              mem_read_req;
  logic              mem_write_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              Main_mem_ack;
  logic              grant_id;
  logic              busy;

  modport master (
    input  req0_valid, req0_write, req0_addr,
    input  req1_valid, req1_write, req1_addr,
    input  Main_mem_ack,
    output req0_ack, req0_err, req1_ack, req1_err,
    output mem_read_req, mem_write_req, mem_addr,
    output grant_id, busy
  );

  modport slave (
    output req0_valid, req0_write, req0_addr,
    output req1_valid, req1_write, req1_addr,
    output Main_mem_ack,
    input  req0_ack, req0_err, req1_ack, req1_err,
    input  mem_read_req, mem_write_req, mem_addr,
    input  grant_id, busy
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one main-memory port between two cache controllers,
// with a watchdog that ends transactions whose memory ack never arrives.
module mem_req_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              reset,
  mem_req_arbiter_if.master bus
);

  localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_q;
  state_t            state_d;
  logic              grant_sel;
  logic              timeout_hit;
  logic              gnt_q;
  logic              ptr_q;
  logic              wr_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WD_W-1:0]   wd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Grant choice only matters in IDLE; the pointer breaks ties when both ask.
  always_comb begin
    state_d     = state_q;
    grant_sel   = ptr_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) grant_sel = ptr_q;
        else if (bus.req1_valid)              grant_sel = 1'b1;
        else                                  grant_sel = 1'b0;
        if (bus.req0_valid || bus.req1_valid) state_d = BUSY;
      end
      BUSY: begin
        if (bus.Main_mem_ack) begin
          state_d = RESP;
        end else if (WD_EN && (wd_q == WD_LAST)) begin
          timeout_hit = 1'b1;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction copies are taken at grant so later requester changes cannot leak to memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q  <= 1'b0;
      ptr_q  <= 1'b0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (state_d == BUSY) begin
            gnt_q  <= grant_sel;
            wr_q   <= grant_sel ? bus.req1_write : bus.req0_write;
            addr_q <= grant_sel ? bus.req1_addr : bus.req0_addr;
            wd_q   <= '0;
            err_q  <= 1'b0;
          end
        end
        BUSY: begin
          if (bus.Main_mem_ack)  err_q <= 1'b0;
          else if (timeout_hit)  err_q <= 1'b1;
          else if (WD_EN)        wd_q  <= wd_q + 1'b1;
        end
        RESP:    ptr_q <= ~gnt_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_read_req  = (state_q == BUSY) && !wr_q;
    bus.mem_write_req = (state_q == BUSY) && wr_q;
    bus.mem_addr      = addr_q;
    bus.grant_id      = gnt_q;
    bus.busy          = (state_q != IDLE);
    bus.req0_ack      = (state_q == RESP) && !gnt_q;
    bus.req1_ack      = (state_q == RESP) && gnt_q;
    bus.req0_err      = (state_q == RESP) && !gnt_q && err_q;
    bus.req1_err      = (state_q == RESP) && gnt_q && err_q;
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: the driver queues the expected {id, err} of
// each transaction and a negedge monitor checks every ack pulse against the queue.
module tb_mem_req_arbiter;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  logic [1:0] sb[$];

  mem_req_arbiter_if #(.ADDR_W(32)) bus ();

  mem_req_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in IDLE with the request(s) already raised; returns in the RESP cycle.
  task automatic apply_stimulus(input bit exp_gnt, input bit exp_wr, input logic [31:0] exp_addr,
                                input int ack_cycle, input int exp_len, input bit exp_err,
                                input bit drop);
    int cycles;
    sb.push_back({exp_gnt, exp_err});
    tick();
    cycles = 0;
    while ((bus.mem_read_req || bus.mem_write_req) && cycles < 20) begin
      cycles++;
      check_output("mem_write_req", bus.mem_write_req, exp_wr);
      check_output("mem_read_req", bus.mem_read_req, !exp_wr);
      check_output("mem_addr", bus.mem_addr, exp_addr);
      check_output("grant_id", bus.grant_id, exp_gnt);
      if (cycles == 1) begin
        if (exp_gnt) begin bus.req1_addr = ~exp_addr; bus.req1_write = ~exp_wr; end
        else         begin bus.req0_addr = ~exp_addr; bus.req0_write = ~exp_wr; end
      end
      bus.Main_mem_ack = (cycles == ack_cycle);
      tick();
    end
    bus.Main_mem_ack = 1'b0;
    check_output("busy_len", cycles, exp_len);
    check_output("resp_busy", bus.busy, 1);
    if (drop) begin
      if (exp_gnt) bus.req1_valid = 1'b0;
      else         bus.req0_valid = 1'b0;
    end
  endtask

  // Every ack must be single, expected, and match the queued id/err.
  always @(negedge clk) begin
    logic [1:0] exp;
    if (reset) begin
      if (bus.busy) check_output("req_excl", bus.mem_read_req & bus.mem_write_req, 0);
      if (bus.req0_ack || bus.req1_ack) begin
        check_output("ack_onehot", 32'(bus.req0_ack) + 32'(bus.req1_ack), 1);
        check_output("ack_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          exp = sb.pop_front();
          check_output("ack_id", bus.req1_ack, exp[1]);
          check_output("ack_err", bus.req1_ack ? bus.req1_err : bus.req0_err, exp[0]);
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = '0;
    bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = '0;
    bus.Main_mem_ack = 0;
    tick();
    tick();
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_grant", bus.grant_id, 0);
    check_output("rst_rd", bus.mem_read_req, 0);
    check_output("rst_wr", bus.mem_write_req, 0);
    check_output("rst_addr", bus.mem_addr, 0);
    check_output("rst_ack", {bus.req0_ack, bus.req1_ack, bus.req0_err, bus.req1_err}, 0);
    reset = 1'b1;
    tick();

    // Single read, memory acks on the 3rd BUSY cycle
    bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 32'h1000;
    apply_stimulus(0, 0, 32'h1000, 3, 3, 0, 1);
    tick();
    check_output("t1_idle", bus.busy, 0);
    check_output("t1_ack_seen", sb.size(), 0);

    // Writeback from requester 1
    bus.req1_valid = 1; bus.req1_write = 1; bus.req1_addr = 32'hABC0;
    apply_stimulus(1, 1, 32'hABC0, 2, 2, 0, 1);
    tick();
    check_output("t2_idle", bus.busy, 0);
    check_output("t2_ack_seen", sb.size(), 0);

    // Watchdog expiry with no memory ack
    bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 32'h2000;
    apply_stimulus(0, 0, 32'h2000, 0, 4, 1, 1);
    tick();
    check_output("t3_ack_seen", sb.size(), 0);

    // Ack coinciding with the last watchdog cycle wins
    bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 32'h3000;
    apply_stimulus(0, 0, 32'h3000, 4, 4, 0, 1);
    tick();
    check_output("t4_ack_seen", sb.size(), 0);

    // Spurious memory acks in IDLE and in RESP
    bus.Main_mem_ack = 1;
    tick();
    bus.Main_mem_ack = 0;
    check_output("t5_idle_busy", bus.busy, 0);
    check_output("t5_idle_rd", bus.mem_read_req, 0);
    bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 32'h4000;
    apply_stimulus(1, 0, 32'h4000, 1, 1, 0, 1);
    bus.Main_mem_ack = 1;
    tick();
    bus.Main_mem_ack = 0;
    check_output("t5_resp_idle", bus.busy, 0);
    tick();
    check_output("t5_still_idle", bus.busy, 0);
    check_output("t5_ack_seen", sb.size(), 0);

    // Reset during the 2nd BUSY cycle aborts silently
    bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 32'h5000;
    tick();
    tick();
    check_output("t6_pre_rd", bus.mem_read_req, 1);
    check_output("t6_pre_grant", bus.grant_id, 1);
    #2;
    reset = 1'b0;
    #1;
    check_output("t6_rd", bus.mem_read_req, 0);
    check_output("t6_busy", bus.busy, 0);
    check_output("t6_grant", bus.grant_id, 0);
    bus.req1_valid = 0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    check_output("t6_idle", bus.busy, 0);

    // Contention from reset: pointer alternates 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 32'h6000;
      bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 32'h7000;
      apply_stimulus(i[0], 0, i[0] ? 32'h7000 : 32'h6000, 1, 1, 0, 0);
      tick();
      check_output("t7_ack_seen", sb.size(), 0);
    end
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    tick();
    tick();
    check_output("final_idle", bus.busy, 0);
    check_output("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single main-memory port between two cache controllers, requester 0 and requester 1 (for example, the I-cache and D-cache miss/writeback engines).
- Each requester presents one read or write transaction at a time. The arbiter grants round-robin, drives mem_read_req/mem_write_req/mem_addr to main memory and waits for Main_mem_ack.
- It returns a one-cycle ack to the winning requester.
- A watchdog terminates transactions that never receive Main_mem_ack and flags an error.

Parameters:
- ADDR_W, 32, width of transaction address.
- TIMEOUT_CYCLES, 255, max cycles a memory request is held without Main_mem_ack; 0 disables the watchdog.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has a transaction pending; held until req0_ack.
- req0_write  input  1  1 = writeback, 0 = allocate read; valid with req0_valid.
- req0_addr  input  ADDR_W  transaction address.
- req0_ack  output  1  one-cycle completion pulse to requester 0.
- req0_err  output  1  qualifies req0_ack: transaction timed out.
- req1_valid, req1_write, req1_addr, req1_ack, req1_err: same as requester 0, for requester 1.
- mem_read_req  output  1  read request to main memory.
- mem_write_req  output  1  write request to main memory.
- mem_addr  output  ADDR_W  latched address of the granted transaction.
- Main_mem_ack  input  1  memory completion, single cycle.
- grant_id  output  1  requester currently owning the memory port.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous, reset low): all outputs 0; state = IDLE; priority pointer = requester 0; watchdog counter = 0.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester pointed to by the priority pointer is granted.
  - On the grant edge: latch grant_id, write and addr; clear the watchdog; move to BUSY.
  - With no valid, stay in IDLE.
- BUSY:
  - mem_write_req = latched write, mem_read_req = !latched write, and mem_addr = latched addr, all registered and held for every BUSY cycle.
  - mem_read_req and mem_write_req are never high together.
  - Main_mem_ack sampled high: go to RESP with err = 0.
  - Else if TIMEOUT_CYCLES != 0 and the watchdog equals TIMEOUT_CYCLES-1: go to RESP with err = 1. Memory requests are therefore high for exactly TIMEOUT_CYCLES cycles.
  - Else increment the watchdog.
  - Ack arriving on the same cycle as timeout expiry: ack wins, err = 0.
- RESP (one cycle):
  - reqN_ack = 1 for the granted N only; reqN_err = the recorded err; mem_read_req = mem_write_req = 0.
  - The priority pointer flips to the non-granted requester.
  - Next state is IDLE unconditionally. reqN_valid is ignored during RESP, and a requester may drop or re-raise valid in the ack cycle.
- Latency:
  - valid sampled at edge E gives memory request visible after E.
  - Main_mem_ack sampled at edge K gives ack pulse in cycle after K, with IDLE one cycle later.
  - Minimum transaction length is 3 cycles (IDLE, BUSY, RESP).
- Main_mem_ack in IDLE or RESP is ignored; it causes no state change and no ack.
- reqN_write/reqN_addr changes after grant have no effect, because the latched copies drive memory.
- grant_id holds its last value in IDLE. busy = (state != IDLE).
- reset asserted mid-transaction: everything returns to reset values immediately and no ack is produced. Requesters must reissue.
- Widths: watchdog is $clog2(TIMEOUT_CYCLES+1) bits, clamped to a minimum of 1 bit, and never wraps because it is cleared on grant.

Test Plan:
- Single read: req0_valid=1, write=0, addr=0x1000; Main_mem_ack high on the 3rd BUSY cycle -> mem_read_req high for 3 cycles with mem_addr=0x1000, then req0_ack=1 and req0_err=0 for one cycle, busy=0 the cycle after.
- Contention from reset: req0 and req1 valid together, each acked after 1 cycle -> grant order is 0, 1, 0, 1 over four transactions; exactly one req*_ack per transaction.
- Writeback path: req1_valid, write=1, addr=0xABC0 -> mem_write_req=1, mem_read_req=0 throughout BUSY; req1_ack after Main_mem_ack.
- Timeout with TIMEOUT_CYCLES=4 and no Main_mem_ack -> request high for exactly 4 cycles, then req0_ack=1 and req0_err=1; same setup with ack on the 4th cycle gives err=0.
- Spurious ack: Main_mem_ack pulsed while IDLE and again during RESP -> no state change, no extra ack pulses.
- Reset mid-BUSY: deassert reset during the 2nd BUSY cycle -> mem_read_req, busy and grant_id fall to 0 asynchronously; after release, the pointer favours requester 0 and no ack is emitted for the aborted transaction.
